atp_payment_controller: RTL and testbench
=========================================

# atp_payment_controller

Parametrised payment-session controller for the Any-Time-Payment kiosk: sequences touch → bill scan → cash collection → change/refund → receipt print, with configurable amount width, note limit and inactivity timeout. Replaces the fixed 10-bit single-path flow in the ATP top level with explicit valid/ready handshakes, change computation, cancel/refund and timeout handling. Sits between the kiosk front-end (touch, scanner, cash acceptor) and the receipt printer.

## Interface

- AMT_W, 10, width of all amount buses (rupees, unsigned)
- MAX_NOTES, 8, maximum notes accepted per session (≥1)
- TIMEOUT, 1000, inactivity limit in clk cycles (≥2)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- user_touch  in  1  session start request, sampled in IDLE
- scan_start  in  1  begin bill scan, sampled in WAIT_SCAN
- scan_done  in  1  scan result valid, qualifies bill_amount
- bill_amount  in  AMT_W  amount due
- cash_valid  in  1  one note inserted this cycle
- cash_inserted  in  AMT_W  note value, qualified by cash_valid
- cancel  in  1  user abort
- printer_ready  in  1  printer accepts receipt
- busy  out  1  high whenever state ≠ IDLE
- change_valid  out  1  one-cycle pulse
- change_amount  out  AMT_W  held from change_valid until next session start
- refund_valid  out  1  one-cycle pulse
- refund_amount  out  AMT_W  held from refund_valid until next session start
- print_valid  out  1  receipt request, held until printer_ready
- print_paid  out  AMT_W  amount credited (= due), stable while print_valid
- ack_printed  out  1  one-cycle pulse, receipt completed
- timeout_err  out  1  one-cycle pulse on inactivity abort

## Operation

- States: IDLE, WAIT_SCAN, SCANNING, COLLECT, CHANGE, PRINT, REFUND.
- IDLE: user_touch → WAIT_SCAN; clear paid, note count, held amounts.
- WAIT_SCAN: scan_start → SCANNING. SCANNING: scan_done → latch due=bill_amount; due==0 → PRINT, else COLLECT.
- COLLECT: each cash_valid adds cash_inserted to paid (AMT_W+1-bit accumulator, no overflow possible since notes only accepted while paid<due), increments note count.
  - paid+note ≥ due → CHANGE; change_amount = paid+note−due (always < 2^AMT_W).
  - else note count reaches MAX_NOTES → REFUND with refund_amount = paid+note.
  - cancel → REFUND, refund_amount = paid (plus the same-cycle note if cash_valid; cancel wins over completion).
- CHANGE: one cycle, change_valid=1 (even if change_amount=0) → PRINT.
- PRINT: print_valid=1, print_paid=due; on print_valid&printer_ready → IDLE, ack_printed pulses next cycle.
- REFUND: one cycle, refund_valid=1 → IDLE.
- Timeout: counter reloads on every state entry and every accepted note/strobe; reaching TIMEOUT in WAIT_SCAN/SCANNING → IDLE, timeout_err pulse; in COLLECT → REFUND (refund paid, may be 0) plus timeout_err pulse. No timeout in CHANGE/PRINT/REFUND.
- cancel in WAIT_SCAN/SCANNING → IDLE, no pulses; ignored in IDLE/CHANGE/PRINT/REFUND.
- cash_valid outside COLLECT ignored (no accumulate). scan_done outside SCANNING ignored.
- Same-cycle cash_valid and timeout expiry in COLLECT: note accepted, timer reloads, no timeout.

## Timing

- Reset (async assert, sync-clean deassert): state IDLE; all outputs 0; accumulators, counters cleared. Reset mid-session discards paid with no refund pulse.
- All outputs registered. Input on edge N → state change visible after edge N.
- Note on edge N → paid updated after N; covering note → change_valid high cycle N+1, print_valid from N+2.
- Handshake on edge P → ack_printed high P+1 only, busy low P+1.
- Minimum session (due=0): touch, scan_start, scan_done, then print_valid next cycle.

## Test plan

- Exact pay: due=150, notes 100,50, printer_ready=1 → change_valid with change_amount=0, print_paid=150, single ack_printed pulse, busy returns 0.
- Overpay with printer backpressure: due=120, note 200, printer_ready low 5 cycles → change_amount=80, print_valid held 5 cycles, ack one cycle after ready.
- Cancel with same-cycle note: due=300, notes 100 then (50+cancel) → refund_amount=150, no print_valid, no ack.
- Note limit: MAX_NOTES=3, due=500, three 100 notes → refund_amount=300 after third note.
- Timeout: TIMEOUT=20, due=200, one 50 note then idle → refund_amount=50 and timeout_err exactly 20 cycles after note; WAIT_SCAN idle 20 cycles → IDLE, timeout_err, no refund.
- Reset mid-COLLECT after 100 paid → all outputs 0 immediately, IDLE, later session starts clean (change/refund amounts 0).

Source files
------------

// File: rtl/atp_payment_controller.sv
// Any-Time-Payment session controller: touch, scan, collect cash,
// return change or refund, then hand the receipt to the printer.
module atp_payment_controller #(
   parameter int AMT_W     = 10,
   parameter int MAX_NOTES = 8,
   parameter int TIMEOUT   = 1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             user_touch,
   input  logic             scan_start,
   input  logic             scan_done,
   input  logic [AMT_W-1:0] bill_amount,
   input  logic             cash_valid,
   input  logic [AMT_W-1:0] cash_inserted,
   input  logic             cancel,
   input  logic             printer_ready,
   output logic             busy,
   output logic             change_valid,
   output logic [AMT_W-1:0] change_amount,
   output logic             refund_valid,
   output logic [AMT_W-1:0] refund_amount,
   output logic             print_valid,
   output logic [AMT_W-1:0] print_paid,
   output logic             ack_printed,
   output logic             timeout_err
);

   localparam int CW = $clog2(MAX_NOTES + 1);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] N_LAST = CW'(MAX_NOTES - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, WAIT_SCAN, SCANNING, COLLECT, CHANGE, PRINT, REFUND
   } state_t;

   state_t           state;
   logic [AMT_W:0]   paid;
   logic [AMT_W:0]   sum;
   logic [AMT_W-1:0] due;
   logic [CW-1:0]    cnt;
   logic [TW-1:0]    timer;
   logic             expire;

   assign sum    = paid + {1'b0, cash_inserted};
   assign expire = (timer == T_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         paid          <= '0;
         due           <= '0;
         cnt           <= '0;
         timer         <= '0;
         busy          <= 1'b0;
         change_valid  <= 1'b0;
         change_amount <= '0;
         refund_valid  <= 1'b0;
         refund_amount <= '0;
         print_valid   <= 1'b0;
         print_paid    <= '0;
         ack_printed   <= 1'b0;
         timeout_err   <= 1'b0;
      end else begin
         change_valid <= 1'b0;
         refund_valid <= 1'b0;
         ack_printed  <= 1'b0;
         timeout_err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (user_touch) begin
                  state         <= WAIT_SCAN;
                  busy          <= 1'b1;
                  timer         <= '0;
                  paid          <= '0;
                  cnt           <= '0;
                  due           <= '0;
                  change_amount <= '0;
                  refund_amount <= '0;
               end
            end
            WAIT_SCAN: begin
               if (cancel) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (scan_start) begin
                  state <= SCANNING;
                  timer <= '0;
               end else if (expire) begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  timeout_err <= 1'b1;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            SCANNING: begin
               if (cancel) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (scan_done) begin
                  due   <= bill_amount;
                  timer <= '0;
                  if (bill_amount == '0) begin
                     state       <= PRINT;
                     print_valid <= 1'b1;
                     print_paid  <= '0;
                  end else begin
                     state <= COLLECT;
                  end
               end else if (expire) begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  timeout_err <= 1'b1;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            COLLECT: begin
               if (cancel) begin
                  // a note landing with cancel is still returned
                  state         <= REFUND;
                  refund_valid  <= 1'b1;
                  refund_amount <= cash_valid ? sum[AMT_W-1:0] : paid[AMT_W-1:0];
                  if (cash_valid) paid <= sum;
               end else if (cash_valid) begin
                  paid  <= sum;
                  cnt   <= cnt + CW'(1);
                  timer <= '0;
                  if (sum >= {1'b0, due}) begin
                     state         <= CHANGE;
                     change_valid  <= 1'b1;
                     change_amount <= AMT_W'(sum - {1'b0, due});
                  end else if (cnt == N_LAST) begin
                     state         <= REFUND;
                     refund_valid  <= 1'b1;
                     refund_amount <= sum[AMT_W-1:0];
                  end
               end else if (expire) begin
                  state         <= REFUND;
                  refund_valid  <= 1'b1;
                  refund_amount <= paid[AMT_W-1:0];
                  timeout_err   <= 1'b1;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            CHANGE: begin
               state       <= PRINT;
               print_valid <= 1'b1;
               print_paid  <= due;
            end
            PRINT: begin
               if (printer_ready) begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  print_valid <= 1'b0;
                  print_paid  <= '0;
                  ack_printed <= 1'b1;
               end
            end
            REFUND: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_atp_payment_controller.sv
// Directed bench for atp_payment_controller with small note limit
// and timeout so the limit and expiry paths are reachable quickly.
module tb_atp_payment_controller;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          user_touch = 1'b0;
   logic          scan_start = 1'b0;
   logic          scan_done = 1'b0;
   logic [AW-1:0] bill_amount = '0;
   logic          cash_valid = 1'b0;
   logic [AW-1:0] cash_inserted = '0;
   logic          cancel = 1'b0;
   logic          printer_ready = 1'b0;
   logic          busy;
   logic          change_valid;
   logic [AW-1:0] change_amount;
   logic          refund_valid;
   logic [AW-1:0] refund_amount;
   logic          print_valid;
   logic [AW-1:0] print_paid;
   logic          ack_printed;
   logic          timeout_err;

   int n_checks = 0;
   int n_errors = 0;

   atp_payment_controller #(
      .AMT_W(AW), .MAX_NOTES(3), .TIMEOUT(20)
   ) dut (
      .clk(clk), .reset(reset),
      .user_touch(user_touch), .scan_start(scan_start),
      .scan_done(scan_done), .bill_amount(bill_amount),
      .cash_valid(cash_valid), .cash_inserted(cash_inserted),
      .cancel(cancel), .printer_ready(printer_ready),
      .busy(busy), .change_valid(change_valid),
      .change_amount(change_amount), .refund_valid(refund_valid),
      .refund_amount(refund_amount), .print_valid(print_valid),
      .print_paid(print_paid), .ack_printed(ack_printed),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [AW-1:0] due);
      user_touch = 1'b1; tick(); user_touch = 1'b0;
      scan_start = 1'b1; tick(); scan_start = 1'b0;
      bill_amount = due;
      scan_done = 1'b1; tick(); scan_done = 1'b0;
   endtask

   task automatic note(input logic [AW-1:0] v);
      cash_valid = 1'b1; cash_inserted = v;
      tick();
      cash_valid = 1'b0;
   endtask

   initial begin
      tick(); tick();
      check("rst_busy", busy, 0);
      check("rst_pv", print_valid, 0);
      check("rst_ref", refund_amount, 0);
      @(negedge clk); reset = 1'b1;
      tick();

      // exact pay
      printer_ready = 1'b1;
      start(150);
      check("t1_busy", busy, 1);
      note(100);
      check("t1_cv_early", change_valid, 0);
      note(50);
      check("t1_cv", change_valid, 1);
      check("t1_chg", change_amount, 0);
      tick();
      check("t1_cv_pulse", change_valid, 0);
      check("t1_pv", print_valid, 1);
      check("t1_paid", print_paid, 150);
      tick();
      check("t1_ack", ack_printed, 1);
      check("t1_busy_lo", busy, 0);
      check("t1_pv_lo", print_valid, 0);
      tick();
      check("t1_ack_pulse", ack_printed, 0);

      // overpay with printer backpressure
      printer_ready = 1'b0;
      start(120);
      note(200);
      check("t2_cv", change_valid, 1);
      check("t2_chg", change_amount, 80);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t2_pv_held", print_valid, 1);
         check("t2_no_ack", ack_printed, 0);
      end
      check("t2_paid", print_paid, 120);
      printer_ready = 1'b1;
      tick();
      check("t2_ack", ack_printed, 1);
      check("t2_busy_lo", busy, 0);
      tick();
      check("t2_ack_pulse", ack_printed, 0);
      check("t2_chg_hold", change_amount, 80);

      // cancel with same-cycle note
      start(300);
      check("t3_chg_clr", change_amount, 0);
      note(100);
      cancel = 1'b1;
      note(50);
      cancel = 1'b0;
      check("t3_rv", refund_valid, 1);
      check("t3_ref", refund_amount, 150);
      check("t3_pv", print_valid, 0);
      tick();
      check("t3_busy_lo", busy, 0);
      check("t3_rv_pulse", refund_valid, 0);
      check("t3_no_ack", ack_printed, 0);

      // note limit
      start(500);
      check("t4_ref_clr", refund_amount, 0);
      note(100);
      note(100);
      check("t4_rv_early", refund_valid, 0);
      note(100);
      check("t4_rv", refund_valid, 1);
      check("t4_ref", refund_amount, 300);
      tick();
      check("t4_busy_lo", busy, 0);

      // timeout in COLLECT
      start(200);
      note(50);
      for (int i = 1; i < 20; i++) begin
         tick();
         check("t5_no_to", timeout_err, 0);
      end
      tick();
      check("t5_to", timeout_err, 1);
      check("t5_rv", refund_valid, 1);
      check("t5_ref", refund_amount, 50);
      tick();
      check("t5_to_pulse", timeout_err, 0);
      check("t5_busy_lo", busy, 0);

      // timeout in WAIT_SCAN
      user_touch = 1'b1; tick(); user_touch = 1'b0;
      for (int i = 1; i < 20; i++) tick();
      check("t6_busy", busy, 1);
      tick();
      check("t6_to", timeout_err, 1);
      check("t6_busy_lo", busy, 0);
      check("t6_no_rv", refund_valid, 0);

      // cancel in WAIT_SCAN
      tick();
      user_touch = 1'b1; tick(); user_touch = 1'b0;
      cancel = 1'b1; tick(); cancel = 1'b0;
      check("t7_busy_lo", busy, 0);
      check("t7_no_rv", refund_valid, 0);
      check("t7_no_to", timeout_err, 0);

      // zero-due minimum session
      tick();
      start(0);
      check("t8_pv", print_valid, 1);
      check("t8_paid", print_paid, 0);
      tick();
      check("t8_ack", ack_printed, 1);

      // reset mid-collect
      tick();
      start(400);
      note(100);
      #2 reset = 1'b0;
      #1;
      check("t9_busy", busy, 0);
      check("t9_rv", refund_valid, 0);
      check("t9_ref", refund_amount, 0);
      @(negedge clk); reset = 1'b1;
      tick();
      check("t9_idle", busy, 0);
      start(100);
      check("t9_clean_chg", change_amount, 0);
      check("t9_clean_ref", refund_amount, 0);
      note(60);
      note(60);
      check("t9_chg", change_amount, 20);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
